// File: rtl/tinyalu_core.sv
// rtl/tinyalu_core.sv - TinyALU datapath: one-cycle add/and/xor, three-stage multiply
// Start/done handshake; start must see a low cycle before each request is accepted.
module tinyalu_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL1 = 3'd2,
    S_MUL2 = 3'd3,
    S_MUL3 = 3'd4
  } state_e;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  state_e      state_q;
  logic        start_q;
  logic [7:0]  a_q, b_q;
  logic [2:0]  op_q;
  logic [7:0]  ma_q, mb_q;
  logic [11:0] pp_lo_q, pp_hi_q;
  logic        done_q;
  logic [15:0] result_q;

  logic        op_valid_d;
  logic        accept_d;
  logic [15:0] exec_d;
  logic [15:0] mul_d;

  always_comb begin
    op_valid_d = 1'b0;
    case (op)
      OP_ADD, OP_AND, OP_XOR, OP_MUL: op_valid_d = 1'b1;
      default:                        op_valid_d = 1'b0;
    endcase
  end

  // Rising-edge detect on start: a held-high start cannot retrigger.
  assign accept_d = (state_q == S_IDLE) && start && !start_q && op_valid_d;

  always_comb begin
    exec_d = 16'h0000;
    case (op_q)
      OP_ADD:  exec_d = {7'b0, ({1'b0, a_q} + {1'b0, b_q})};
      OP_AND:  exec_d = {8'b0, (a_q & b_q)};
      OP_XOR:  exec_d = {8'b0, (a_q ^ b_q)};
      default: exec_d = 16'h0000;
    endcase
  end

  // Final multiply stage: low-nibble and high-nibble partial products recombined.
  assign mul_d = {4'b0, pp_lo_q} + {pp_hi_q, 4'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      op_q     <= 3'b000;
      ma_q     <= 8'h00;
      mb_q     <= 8'h00;
      pp_lo_q  <= 12'h000;
      pp_hi_q  <= 12'h000;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
    end else begin
      start_q <= start;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= op;
            state_q <= (op == OP_MUL) ? S_MUL1 : S_EXEC;
          end
        end
        S_EXEC: begin
          result_q <= exec_d;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
        S_MUL1: begin
          ma_q    <= a_q;
          mb_q    <= b_q;
          state_q <= S_MUL2;
        end
        S_MUL2: begin
          pp_lo_q <= {4'b0, ma_q} * {8'b0, mb_q[3:0]};
          pp_hi_q <= {4'b0, ma_q} * {8'b0, mb_q[7:4]};
          state_q <= S_MUL3;
        end
        S_MUL3: begin
          result_q <= mul_d;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: doc/tinyalu_core.md
# tinyalu_core

Synthesizable TinyALU datapath: the design under test whose `done`/`result` the ALU scoreboard checks every clock. It accepts one 8-bit operand pair and opcode per transaction over a start/done handshake. It executes add/and/xor in one cycle and multiply in a three-stage internal pipeline. It returns a 16-bit result with a single-cycle `done` pulse.

## Interface

- No parameters; widths fixed: operands 8 bits, result 16 bits, opcode 3 bits.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- A  in  8  operand A, unsigned.
- B  in  8  operand B, unsigned.
- op  in  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul; 101/110/111 reserved.
- start  in  1  request; level-held by driver until `done`.
- done  out  1  one-cycle pulse; `result` valid in the same cycle.
- result  out  16  registered result; holds last value until next `done`.
- busy  out  1  high while a transaction is in flight.

## Operation

- States: IDLE, EXEC, MUL1, MUL2, MUL3.
- Acceptance: at a rising edge where state=IDLE, `start`=1, start_q=0, and `op` ∈ {add, and, xor, mul}.
  - start_q is `start` registered the previous cycle.
  - A, B and op are captured into internal registers on that edge.
  - Inputs may change freely after acceptance.
- Acceptance transitions:
  - add/and/xor: IDLE→EXEC.
  - mul: IDLE→MUL1.
- Execution transitions:
  - EXEC→IDLE: register result, pulse `done`.
  - MUL1→MUL2→MUL3→IDLE: `done` and result on the MUL3→IDLE edge.
- Ignored requests (no state change, no `done`, `busy` stays 0):
  - no_op or reserved op.
  - `start` held high without a preceding low cycle.
  - The driver must drop `start` for at least one cycle before the next request.
- `start` while not IDLE is ignored; captured operands are unaffected.
- Arithmetic: all operands unsigned; results zero-extended.
  - add: {7'b0, A+B}; 9-bit sum, no wrap, e.g. 255+255=510.
  - and/xor: {8'b0, A op B}.
  - mul: full 16-bit product A*B; max 255*255=65025, no overflow.
- Mul pipeline: MUL1 registers operands, MUL2 forms partial products, MUL3 sums them. Internal split is free; latency is not.
- `busy` = (state != IDLE).

## Timing

- Reset values: `done`=0, `result`=16'h0000, `busy`=0, state=IDLE, start_q=0.
- Reset mid-transaction: the next edge with `reset`=1 aborts the transaction.
  - No `done` is issued and `result` clears to 0.
  - A request is accepted no earlier than the first edge with `reset`=0.
  - `start` still high out of reset counts as a new request, since start_q=0.
- Latency, with acceptance at edge N:
  - add/and/xor: `done`=1 and `result` valid after edge N+1.
  - mul: `done`=1 and `result` valid after edge N+3.
- `done` is high for exactly one cycle; never two in consecutive cycles.
- `busy` rises after edge N and falls in the same cycle `done` rises.
- Back-to-back: `done` after edge M, driver drops `start` for edge M+1, earliest next acceptance is edge M+2.
- Scoreboard contract: `done` and `result` are registered outputs, stable by 1 time unit after the clock edge.

## Test plan

- Reset, then add A=8'hFF, B=8'hFF → after 1 cycle `done` pulses once, `result`=16'h01FE, `busy` falls together with `done`.
- mul A=8'hFF, B=8'hFF → `done` exactly 3 cycles after acceptance, `result`=16'hFE01; no `done` in the intervening cycles.
- Sequences, dropping `start` one cycle between each:
  - and A=8'hF0, B=8'h3C → `result`=16'h0030.
  - xor A=8'hF0, B=8'h3C → `result`=16'h00CC.
  - no_op A=8'h12, B=8'h34 → no `done`, `result` holds 16'h00CC.
- `start` held high for 10 cycles with op=add, A=1, B=2 → exactly one `done`, `result`=16'h0003.
  - Changing A to 5 while `busy` does not alter the result.
- Start mul A=10, B=10; assert `reset` one cycle after acceptance → no `done`, `result`=0, `busy`=0 after that edge.
  - Then add 3+4 → `result`=16'h0007 one cycle after acceptance.
- Reserved op 3'b110 with `start` → no `done`, `busy` stays 0.
  - A following mul A=8'h02, B=8'h80 → `result`=16'h0100.
